// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - Arbiter PUF challenge/response acquisition sequencer
// Majority voting over REPEAT evaluations is built only when PUF_MAJORITY_VOTE_EN is defined.
module puf_challenge_sequencer #(
  parameter int CHAL_W     = 128,
  parameter int SETTLE_CYC = 16,
  parameter int REPEAT     = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_crp,
  output logic              busy,
  output logic              done,
  output logic              lfsr_en,
  input  logic [CHAL_W-1:0] lfsr_stage,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_launch,
  input  logic              puf_resp,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CHAL_W-1:0] crp_challenge,
  output logic              crp_response,
  output logic [CNT_W-1:0]  crp_index
);

  localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1 || REPEAT < 1 || (REPEAT % 2) == 0) begin : g_bad_cfg
    $error("puf_challenge_sequencer: SETTLE_CYC must be >= 1 and REPEAT odd and >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_LATCH, S_LAUNCH, S_SAMPLE, S_REST, S_OUTPUT, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] num_lat;
  logic             timer_last;
  logic             last_crp;
  logic             evals_left;
  logic             resp_dec;

  assign timer_last = (timer == TIMER_LAST);
  assign last_crp   = ((crp_index + CNT_W'(1)) == num_lat);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VW = $clog2(REPEAT + 1);
  logic [VW-1:0] ones;
  logic [VW-1:0] evals;

  assign evals_left = (int'(evals) < REPEAT);
  assign resp_dec   = (int'(ones) > REPEAT / 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ones  <= '0;
      evals <= '0;
    end else if (state == S_LATCH) begin
      ones  <= '0;
      evals <= '0;
    end else if (state == S_SAMPLE) begin
      ones  <= ones + VW'(puf_resp);
      evals <= evals + VW'(1);
    end
  end
`else
  logic sample_q;

  assign evals_left = 1'b0;
  assign resp_dec   = sample_q;

  always_ff @(posedge clk) begin
    if (rst)                    sample_q <= 1'b0;
    else if (state == S_SAMPLE) sample_q <= puf_resp;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Control outputs decode straight from the state so abort drops them on the very next edge.
  always_comb begin
    state_nx   = state;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    lfsr_en    = (state == S_STEP);
    puf_launch = (state == S_LAUNCH);
    crp_valid  = (state == S_OUTPUT);
    case (state)
      S_IDLE:   if (start) state_nx = (num_crp == '0) ? S_DONE : S_STEP;
      S_STEP:   state_nx = S_LATCH;
      S_LATCH:  state_nx = S_LAUNCH;
      S_LAUNCH: if (timer_last) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = S_REST;
      S_REST:   if (timer_last) state_nx = evals_left ? S_LAUNCH : S_OUTPUT;
      S_OUTPUT: if (crp_ready) state_nx = last_crp ? S_DONE : S_STEP;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer         <= '0;
      num_lat       <= '0;
      crp_index     <= '0;
      puf_challenge <= '0;
      crp_challenge <= '0;
      crp_response  <= 1'b0;
    end else begin
      if (state == S_LAUNCH || state == S_REST)
        timer <= timer_last ? '0 : timer + TW'(1);
      else
        timer <= '0;

      if (state == S_IDLE && start && !abort && num_crp != '0) begin
        num_lat   <= num_crp;
        crp_index <= '0;
      end

      // Challenge only moves in LATCH, so it is frozen through every launch and rest window.
      if (state == S_LATCH)
        puf_challenge <= lfsr_stage;

      if (state == S_REST && timer_last && !evals_left) begin
        crp_challenge <= puf_challenge;
        crp_response  <= resp_dec;
      end

      if (state == S_OUTPUT && crp_ready && !abort && !last_crp)
        crp_index <= crp_index + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - randomized self-checking bench for puf_challenge_sequencer
// Honours PUF_MAJORITY_VOTE_EN the same way as the design.
module tb_puf_challenge_sequencer;

  localparam int CHAL_W = 128;
  localparam int SETTLE = 16;
  localparam int REPEAT = 5;
  localparam int CNT_W  = 16;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EVALS = REPEAT;
`else
  localparam int EVALS = 1;
`endif
  localparam int FIRST_VALID = 2 + EVALS * (2 * SETTLE + 1);

  logic              clk = 1'b0;
  logic              rst, start, abort, busy, done, lfsr_en;
  logic [CNT_W-1:0]  num_crp;
  logic [CHAL_W-1:0] lfsr_stage, puf_challenge, crp_challenge;
  logic              puf_launch, puf_resp, crp_valid, crp_ready, crp_response;
  logic [CNT_W-1:0]  crp_index;

  puf_challenge_sequencer #(
    .CHAL_W(CHAL_W), .SETTLE_CYC(SETTLE), .REPEAT(REPEAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_crp(num_crp),
    .busy(busy), .done(done), .lfsr_en(lfsr_en), .lfsr_stage(lfsr_stage),
    .puf_challenge(puf_challenge), .puf_launch(puf_launch), .puf_resp(puf_resp),
    .crp_valid(crp_valid), .crp_ready(crp_ready), .crp_challenge(crp_challenge),
    .crp_response(crp_response), .crp_index(crp_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: challenges stepped but not yet delivered, response bits fed per evaluation.
  logic [127:0] chal_q[$];
  bit           resp_src[$];
  bit           samples[$];
  bit           resp_log[$];
  int           exp_idx, run_len, crp_cnt, done_cnt, step_cnt, launch_cnt, launch_run, since_step;
  bit           prev_launch, prev_valid, prev_hs, prev_abort;
  logic [127:0] held_chal;
  logic         held_resp;
  logic [CNT_W-1:0] held_idx;

  function automatic logic [127:0] lfsr_next(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  function automatic logic [127:0] chal_front();
    return (chal_q.size() != 0) ? chal_q[0] : 128'h0;
  endfunction

  function automatic bit majority();
    int n = 0;
    foreach (samples[i]) n += int'(samples[i]);
    return (2 * n > EVALS);
  endfunction

  always @(negedge clk) begin : monitor
    bit b;
    bit hs;
    hs = 1'b0;
    if (rst) begin
      prev_launch = 0; prev_valid = 0; prev_hs = 0; prev_abort = 0; launch_run = 0;
    end else begin
      since_step++;
      if (prev_hs && crp_cnt < run_len) check("step_after_handshake", 128'(lfsr_en), 128'(1));
      if (lfsr_en) begin
        step_cnt++;
        since_step = 0;
        lfsr_stage = lfsr_next(lfsr_stage);
        chal_q.push_back(lfsr_stage);
      end
      if (puf_launch) begin
        if (!prev_launch) begin
          launch_cnt++;
          check("chal_at_launch", puf_challenge, chal_front());
        end
        launch_run++;
        puf_resp = 1'($urandom_range(0, 1));
      end else if (prev_launch && !prev_abort) begin
        check("launch_width", 128'(launch_run), 128'(SETTLE));
        check("chal_at_sample", puf_challenge, chal_front());
        launch_run = 0;
        b = (resp_src.size() != 0) ? resp_src.pop_front() : 1'($urandom_range(0, 1));
        puf_resp = b;
        samples.push_back(b);
      end else begin
        launch_run = 0;
        puf_resp = 1'($urandom_range(0, 1));
      end
      if (crp_valid) begin
        if (!prev_valid) begin
          check("valid_latency", 128'(since_step), 128'(FIRST_VALID));
          check("crp_challenge", crp_challenge, chal_front());
          check("crp_index", 128'(crp_index), 128'(exp_idx));
          check("evals_per_crp", 128'(samples.size()), 128'(EVALS));
          check("crp_response", 128'(crp_response), 128'(majority()));
          held_chal = crp_challenge; held_resp = crp_response; held_idx = crp_index;
        end else begin
          check("hold_challenge", crp_challenge, held_chal);
          check("hold_response", 128'(crp_response), 128'(held_resp));
          check("hold_index", 128'(crp_index), 128'(held_idx));
          check("hold_no_launch", 128'(puf_launch), 128'(0));
          check("hold_no_step", 128'(lfsr_en), 128'(0));
        end
        if (crp_ready) begin
          void'(chal_q.pop_front());
          samples.delete();
          resp_log.push_back(crp_response);
          exp_idx++;
          crp_cnt++;
          hs = 1'b1;
        end
      end
      if (done) done_cnt++;
      prev_hs = hs;
      prev_valid = crp_valid;
      prev_launch = puf_launch;
      prev_abort = abort;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: ready tied 1, 1: random ready, 2: hold off first CRP for 50 cycles, 3: poke start/num_crp mid-run
  task automatic run(input int n, input int mode);
    int d0, s0, l0, cyc, hold;
    d0 = done_cnt; s0 = step_cnt; l0 = launch_cnt;
    exp_idx = 0; crp_cnt = 0; run_len = n; hold = 0; cyc = 0;
    crp_ready = (mode != 2);
    num_crp = CNT_W'(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (done_cnt == d0 && cyc < n * 600 + 100) begin
      case (mode)
        1: crp_ready = 1'($urandom_range(0, 1));
        2: begin
          if (crp_valid) hold++;
          crp_ready = (hold >= 50);
        end
        3: begin
          start = (cyc == 100);
          if (cyc == 100) num_crp = CNT_W'(7);
        end
        default: crp_ready = 1'b1;
      endcase
      tick(1);
      cyc++;
    end
    start = 1'b0;
    crp_ready = 1'b1;
    tick(3);
    check("run_done_once", 128'(done_cnt - d0), 128'(1));
    check("run_crp_count", 128'(crp_cnt), 128'(n));
    check("run_step_count", 128'(step_cnt - s0), 128'(n));
    check("run_launch_count", 128'(launch_cnt - l0), 128'(n * EVALS));
    check("run_idle", 128'(busy), 128'(0));
  endtask

  initial begin : stimulus
    int d0, s0, l0, c0, cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_crp = '0; crp_ready = 1'b1; puf_resp = 1'b0;
    lfsr_stage = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3211;
    done_cnt = 0; step_cnt = 0; launch_cnt = 0; since_step = 0; run_len = 0; crp_cnt = 0; exp_idx = 0;
    tick(3);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_lfsr_en", 128'(lfsr_en), 128'(0));
    check("rst_launch", 128'(puf_launch), 128'(0));
    check("rst_valid", 128'(crp_valid), 128'(0));
    check("rst_puf_challenge", puf_challenge, 128'(0));
    check("rst_crp_challenge", crp_challenge, 128'(0));
    check("rst_crp_response", 128'(crp_response), 128'(0));
    check("rst_crp_index", 128'(crp_index), 128'(0));
    rst = 1'b0;
    tick(2);
    check("idle_busy", 128'(busy), 128'(0));

    // Zero-length run: done pulse only.
    d0 = done_cnt; s0 = step_cnt; l0 = launch_cnt; c0 = crp_cnt;
    num_crp = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("zero_done", 128'(done_cnt - d0), 128'(1));
    check("zero_steps", 128'(step_cnt - s0), 128'(0));
    check("zero_launches", 128'(launch_cnt - l0), 128'(0));
    check("zero_crps", 128'(crp_cnt - c0), 128'(0));

    // Three CRPs, responses all 1.
    resp_log.delete();
    repeat (3 * EVALS) resp_src.push_back(1'b1);
    run(3, 0);
    for (int i = 0; i < 3; i++)
      check("all_ones_resp", 128'(resp_log.size() > i ? resp_log[i] : 1'b0), 128'(1));

    // Vote patterns 1,0,1,0,0 and 1,1,0,0,1.
    resp_log.delete();
    resp_src = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run(2, 0);
`ifdef PUF_MAJORITY_VOTE_EN
    check("vote_pattern_a", 128'(resp_log.size() > 0 ? resp_log[0] : 1'b1), 128'(0));
    check("vote_pattern_b", 128'(resp_log.size() > 1 ? resp_log[1] : 1'b0), 128'(1));
`else
    check("single_pattern_a", 128'(resp_log.size() > 0 ? resp_log[0] : 1'b0), 128'(1));
    check("single_pattern_b", 128'(resp_log.size() > 1 ? resp_log[1] : 1'b1), 128'(0));
`endif
    resp_src.delete();

    // Backpressure, then start/num_crp pokes while busy.
    run(2, 2);
    run(2, 3);

    // Abort during the launch of CRP 1.
    exp_idx = 0; crp_cnt = 0; run_len = 3; crp_ready = 1'b1;
    num_crp = CNT_W'(3); start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (!(crp_index == CNT_W'(1) && puf_launch) && cyc < 1000) begin
      tick(1);
      cyc++;
    end
    check("abort_reached_launch", 128'(puf_launch), 128'(1));
    tick(3);
    d0 = done_cnt;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_launch", 128'(puf_launch), 128'(0));
    check("abort_valid", 128'(crp_valid), 128'(0));
    check("abort_lfsr_en", 128'(lfsr_en), 128'(0));
    chal_q.delete();
    samples.delete();
    tick(5);
    check("abort_no_done", 128'(done_cnt - d0), 128'(0));
    run(1, 0);

    // Abort and start together in IDLE: start is dropped.
    s0 = step_cnt;
    num_crp = CNT_W'(2); start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(3);
    check("abort_start_idle", 128'(busy), 128'(0));
    check("abort_start_steps", 128'(step_cnt - s0), 128'(0));

    for (int k = 0; k < 4; k++) run(int'($urandom_range(1, 4)), int'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
